// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: stage records, halt FSM
// states and the producer-match helper used by stall and forwarding logic.
package pipe_ctrl_pkg;

  // Record rd fields are held at a fixed width; RF_ADDRESS may be at most this.
  localparam int REC_RD_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_rec_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

  function automatic logic rec_writes(input stage_rec_t r, input logic [REC_RD_W-1:0] src);
    return r.valid && r.reg_write && (r.rd != '0) && (r.rd == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority match of one EX source register against MEM1..WB records; the
// youngest producing record wins, loads still in a MEM stage never forward.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int SEL_W      = 2
) (
  input  logic [REC_RD_W-1:0]             src,
  input  logic                            use_src,
  input  stage_rec_t [MEM_STAGES+1:1]     recs,
  output logic [SEL_W-1:0]                sel
);

  always_comb begin
    sel = SEL_W'(FWD_RF);
    // Walk oldest to youngest so the smallest stage index is written last.
    for (int k = MEM_STAGES + 1; k >= 1; k--) begin
      if (use_src && rec_writes(recs[k], src) && !(recs[k].mem_read && (k <= MEM_STAGES))) begin
        sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Centralised hazard control: load-use stalls, forwarding selects, redirect
// flushes and halt draining. Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int MEM_STAGES = 1,
  parameter int SEL_W      = $clog2(MEM_STAGES + 2)  // derived; do not override
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_halt,
  input  logic                  ex_redirect,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic                  halted,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output halt_state_e           dbg_state
);

  localparam int NREC    = MEM_STAGES + 2;
  localparam int DRAIN_W = $clog2(MEM_STAGES + 3);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MEM_STAGES + 2);

  // Index 0 = EX, 1..MEM_STAGES = MEMk, NREC-1 = WB.
  stage_rec_t [NREC-1:0] rec_q, rec_d;
  logic [REC_RD_W-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic                  ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
  halt_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;

  logic [REC_RD_W-1:0]   id_rs1_x, id_rs2_x;
  logic                  load_hit, run, redirect_flush, load_stall, halt_accept;

  assign id_rs1_x = REC_RD_W'(id_rs1);
  assign id_rs2_x = REC_RD_W'(id_rs2);

  // A load is not forwardable until WB, so any load in EX..MEM(N-1) feeding ID stalls.
  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < MEM_STAGES; k++) begin
      if (rec_q[k].mem_read &&
          ((id_use_rs1 && rec_writes(rec_q[k], id_rs1_x)) ||
           (id_use_rs2 && rec_writes(rec_q[k], id_rs2_x)))) begin
        load_hit = 1'b1;
      end
    end
  end

  // Redirect beats stall; outside RUN the front end stays frozen and redirects are ignored.
  always_comb begin
    run            = (state_q == RUN);
    redirect_flush = run && ex_redirect;
    load_stall     = run && id_valid && load_hit && !ex_redirect;
    halt_accept    = run && id_valid && id_halt && !ex_redirect && !load_hit;
    stall_pc       = load_stall || !run;
    stall_ifid     = load_stall || !run;
    flush_ifid     = redirect_flush;
    bubble_idex    = load_stall || redirect_flush || !run;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      RUN: begin
        if (halt_accept) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q <= DRAIN_W'(1)) begin
          drain_cnt_d = '0;
          state_d     = HALTED;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rec_d     = '0;
    ex_rs1_d  = '0;
    ex_rs2_d  = '0;
    ex_use1_d = 1'b0;
    ex_use2_d = 1'b0;
    for (int k = 1; k < NREC; k++) begin
      rec_d[k] = rec_q[k-1];
    end
    if (id_valid && !bubble_idex) begin
      rec_d[0].valid     = 1'b1;
      rec_d[0].rd        = REC_RD_W'(id_rd);
      rec_d[0].reg_write = id_reg_write;
      rec_d[0].mem_read  = id_mem_read;
      ex_rs1_d           = id_rs1_x;
      ex_rs2_d           = id_rs2_x;
      ex_use1_d          = id_use_rs1;
      ex_use2_d          = id_use_rs2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_q       <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_use1_q   <= 1'b0;
      ex_use2_q   <= 1'b0;
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      rec_q       <= rec_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_use1_q   <= ex_use1_d;
      ex_use2_q   <= ex_use2_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign dbg_state = state_q;

  fwd_select #(.MEM_STAGES(MEM_STAGES), .SEL_W(SEL_W)) u_fwd_a (
    .src     (ex_rs1_q),
    .use_src (ex_use1_q),
    .recs    (rec_q[NREC-1:1]),
    .sel     (fwd_a_sel)
  );

  fwd_select #(.MEM_STAGES(MEM_STAGES), .SEL_W(SEL_W)) u_fwd_b (
    .src     (ex_rs2_q),
    .use_src (ex_use2_q),
    .recs    (rec_q[NREC-1:1]),
    .sel     (fwd_b_sel)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, load_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_flush};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (MEM_STAGES 1..3) checked every
// cycle against an instruction-history model, plus directed literal cases.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic v; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic rw; logic mr; logic u1; logic u2;
  } mrec_t;

  typedef struct packed {
    logic ld; logic fl; logic stall; logic bub; logic halted; logic acc;
    logic [2:0] sa; logic [2:0] sb; halt_state_e st;
  } exp_t;

`ifdef HAZARD_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid [3], id_use_rs1 [3], id_use_rs2 [3], id_reg_write [3];
  logic id_mem_read [3], id_halt [3], ex_redirect [3];
  logic [4:0] id_rs1 [3], id_rs2 [3], id_rd [3];
  logic stall_pc [3], stall_ifid [3], flush_ifid [3], bubble_idex [3], halted [3];
  logic [2:0] fa [3], fb [3];
  logic [31:0] scnt [3], fcnt [3];
  halt_state_e dbg [3];

  int n_checks = 0;
  int n_fail = 0;

  // Model: what entered EX at each cycle, indexed by cycle number.
  mrec_t hbuf [3][8];
  int cyc [3];
  int acc_at [3];
  int m_stall_n [3];
  int m_flush_n [3];
  exp_t pe;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SW = $clog2(g + 3);
    logic [SW-1:0] fa_w, fb_w;
    pipe_hazard_ctrl #(.RF_ADDRESS(5), .MEM_STAGES(g + 1)) u_dut (
      .clk(clk), .reset(rst),
      .id_valid(id_valid[g]), .id_rs1(id_rs1[g]), .id_rs2(id_rs2[g]),
      .id_use_rs1(id_use_rs1[g]), .id_use_rs2(id_use_rs2[g]), .id_rd(id_rd[g]),
      .id_reg_write(id_reg_write[g]), .id_mem_read(id_mem_read[g]), .id_halt(id_halt[g]),
      .ex_redirect(ex_redirect[g]),
      .stall_pc(stall_pc[g]), .stall_ifid(stall_ifid[g]), .flush_ifid(flush_ifid[g]),
      .bubble_idex(bubble_idex[g]), .fwd_a_sel(fa_w), .fwd_b_sel(fb_w),
      .halted(halted[g]), .stall_cnt(scnt[g]), .flush_cnt(fcnt[g]), .dbg_state(dbg[g])
    );
    assign fa[g] = 3'(fa_w);
    assign fb[g] = 3'(fb_w);
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    for (int d = 0; d < 8; d++) hbuf[i][d] = '0;
    cyc[i] = 0;
    acc_at[i] = -1;
    m_stall_n[i] = 0;
    m_flush_n[i] = 0;
  endtask

  // Instruction that is d stages past ID-to-EX (0 = EX).
  function automatic mrec_t rec_at(input int i, input int d);
    mrec_t r = '0;
    if (cyc[i] - 1 - d >= 0) r = hbuf[i][(cyc[i] - 1 - d) % 8];
    return r;
  endfunction

  function automatic logic writes(input mrec_t r, input logic [4:0] src);
    return r.v && r.rw && (r.rd != 5'd0) && (r.rd == src);
  endfunction

  function automatic int fsel(input int i, input logic use_it, input logic [4:0] src);
    int ms = i + 1;
    mrec_t r;
    if (!use_it) return 0;
    for (int d = 1; d <= ms + 1; d++) begin
      r = rec_at(i, d);
      if (writes(r, src)) begin
        if (r.mr && d <= ms) continue;
        return d;
      end
    end
    return 0;
  endfunction

  function automatic exp_t predict(input int i);
    exp_t e = '0;
    int ms = i + 1;
    logic run = (acc_at[i] < 0);
    logic hit = 1'b0;
    mrec_t r;
    for (int d = 0; d < ms; d++) begin
      r = rec_at(i, d);
      if (r.mr && id_valid[i] &&
          ((id_use_rs1[i] && writes(r, id_rs1[i])) || (id_use_rs2[i] && writes(r, id_rs2[i]))))
        hit = 1'b1;
    end
    e.ld = run && hit && !ex_redirect[i];
    e.fl = run && ex_redirect[i];
    e.stall = e.ld || !run;
    e.bub = e.ld || e.fl || !run;
    e.halted = !run && (cyc[i] - acc_at[i] >= ms + 3);
    e.acc = run && id_valid[i] && id_halt[i] && !ex_redirect[i] && !hit;
    e.st = run ? RUN : (e.halted ? HALTED : DRAIN);
    r = rec_at(i, 0);
    e.sa = 3'(fsel(i, r.v && r.u1, r.rs1));
    e.sb = 3'(fsel(i, r.v && r.u2, r.rs2));
    return e;
  endfunction

  task automatic model_step(input int i, input exp_t e);
    mrec_t r = '0;
    if (e.acc) acc_at[i] = cyc[i];
    if (!e.bub && id_valid[i]) begin
      r.v = 1'b1; r.rd = id_rd[i]; r.rs1 = id_rs1[i]; r.rs2 = id_rs2[i];
      r.rw = id_reg_write[i]; r.mr = id_mem_read[i]; r.u1 = id_use_rs1[i]; r.u2 = id_use_rs2[i];
    end
    hbuf[i][cyc[i] % 8] = r;
    cyc[i]++;
    m_stall_n[i] += int'(e.ld);
    m_flush_n[i] += int'(e.fl);
  endtask

  // Compare process: inputs settle at negedge, outputs checked before the next posedge.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        model_reset(i);
      end else begin
        pe = predict(i);
        chk("stall_pc", i, int'(stall_pc[i]), int'(pe.stall));
        chk("stall_ifid", i, int'(stall_ifid[i]), int'(pe.stall));
        chk("flush_ifid", i, int'(flush_ifid[i]), int'(pe.fl));
        chk("bubble_idex", i, int'(bubble_idex[i]), int'(pe.bub));
        chk("fwd_a_sel", i, int'(fa[i]), int'(pe.sa));
        chk("fwd_b_sel", i, int'(fb[i]), int'(pe.sb));
        chk("halted", i, int'(halted[i]), int'(pe.halted));
        chk("state", i, int'(dbg[i]), int'(pe.st));
        chk("stall_cnt", i, int'(scnt[i]), PERF_ON * m_stall_n[i]);
        chk("flush_cnt", i, int'(fcnt[i]), PERF_ON * m_flush_n[i]);
        model_step(i, pe);
      end
    end
  end

  task automatic set_id(input int i, input logic v, input int rs1, input int rs2, input logic u1,
                        input logic u2, input int rd, input logic rw, input logic mr, input logic hl);
    id_valid[i] = v; id_rs1[i] = 5'(rs1); id_rs2[i] = 5'(rs2);
    id_use_rs1[i] = u1; id_use_rs2[i] = u2; id_rd[i] = 5'(rd);
    id_reg_write[i] = rw; id_mem_read[i] = mr; id_halt[i] = hl;
  endtask

  task automatic idle(input int i);
    set_id(i, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    ex_redirect[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(i);
    @(negedge clk);
    rst = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_stall_pc", i, int'(stall_pc[i]), 0);
      chk("rst_bubble", i, int'(bubble_idex[i]), 0);
      chk("rst_fwd_a", i, int'(fa[i]), 0);
      chk("rst_halted", i, int'(halted[i]), 0);
      chk("rst_state", i, int'(dbg[i]), int'(RUN));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) idle(i);

    // MEM_STAGES=1: lw x5; add x6,x5,x1 -> one stall, then WB forward.
    do_reset();
    @(negedge clk); set_id(0, 1, 0, 0, 0, 0, 5, 1, 1, 0); #3;
    chk("a_lw_nostall", 0, int'(stall_pc[0]), 0);
    @(negedge clk); set_id(0, 1, 5, 1, 1, 1, 6, 1, 0, 0); #3;
    chk("a_use_stall_pc", 0, int'(stall_pc[0]), 1);
    chk("a_use_bubble", 0, int'(bubble_idex[0]), 1);
    @(negedge clk); #3;
    chk("a_use_release", 0, int'(stall_pc[0]), 0);
    @(negedge clk); idle(0); #3;
    chk("a_fwd_wb", 0, int'(fa[0]), 2);
    chk("a_fwd_b_rf", 0, int'(fb[0]), 0);

    // MEM_STAGES=1: add x5; sub x7,x5,x5 -> no stall, both from MEM1.
    do_reset();
    @(negedge clk); set_id(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    @(negedge clk); set_id(0, 1, 5, 5, 1, 1, 7, 1, 0, 0); #3;
    chk("b_nostall", 0, int'(stall_pc[0]), 0);
    @(negedge clk); idle(0); #3;
    chk("b_fwd_a_mem1", 0, int'(fa[0]), 1);
    chk("b_fwd_b_mem1", 0, int'(fb[0]), 1);

    // MEM_STAGES=3: lw x9; user of x9 -> three stalls then WB select 4.
    do_reset();
    @(negedge clk); set_id(2, 1, 0, 0, 0, 0, 9, 1, 1, 0);
    @(negedge clk); set_id(2, 1, 9, 3, 1, 1, 10, 1, 0, 0); #3;
    chk("c_stall1", 2, int'(stall_pc[2]), 1);
    @(negedge clk); #3; chk("c_stall2", 2, int'(stall_pc[2]), 1);
    @(negedge clk); #3; chk("c_stall3", 2, int'(stall_pc[2]), 1);
    @(negedge clk); #3; chk("c_release", 2, int'(stall_pc[2]), 0);
    @(negedge clk); idle(2); #3;
    chk("c_fwd_wb", 2, int'(fa[2]), 4);
    chk("c_stall_cnt", 2, int'(scnt[2]), PERF_ON * 3);

    // x0 is never a producer.
    do_reset();
    @(negedge clk); set_id(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk); set_id(0, 1, 0, 0, 1, 1, 1, 1, 0, 0); #3;
    chk("d_x0_nostall", 0, int'(stall_pc[0]), 0);
    @(negedge clk); idle(0); #3;
    chk("d_x0_sel_a", 0, int'(fa[0]), 0);
    chk("d_x0_sel_b", 0, int'(fb[0]), 0);

    // Redirect together with a load-use stall and a halt in ID.
    do_reset();
    @(negedge clk); set_id(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    @(negedge clk); set_id(0, 1, 5, 0, 1, 0, 0, 0, 0, 1); ex_redirect[0] = 1'b1; #3;
    chk("e_flush", 0, int'(flush_ifid[0]), 1);
    chk("e_stall_pc", 0, int'(stall_pc[0]), 0);
    chk("e_bubble", 0, int'(bubble_idex[0]), 1);
    @(negedge clk); idle(0); #3;
    chk("e_state_run", 0, int'(dbg[0]), int'(RUN));
    chk("e_flush_cnt", 0, int'(fcnt[0]), PERF_ON * 1);

    // MEM_STAGES=2 halt: halted after exactly 5 edges.
    do_reset();
    @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); #3;
    chk("f_accept_nostall", 1, int'(stall_pc[1]), 0);
    @(negedge clk); idle(1); #3;
    chk("f_drain_state", 1, int'(dbg[1]), int'(DRAIN));
    chk("f_drain_stall", 1, int'(stall_pc[1]), 1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); #3; chk("f_not_yet_halted", 1, int'(halted[1]), 0);
    end
    @(negedge clk); #3;
    chk("f_halted", 1, int'(halted[1]), 1);
    chk("f_state_halted", 1, int'(dbg[1]), int'(HALTED));

    // Asynchronous reset in the middle of DRAIN.
    do_reset();
    @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); idle(1);
    @(negedge clk); #3;
    chk("g_in_drain", 1, int'(dbg[1]), int'(DRAIN));
    rst = 1'b1; #1;
    chk("g_async_state", 1, int'(dbg[1]), int'(RUN));
    chk("g_async_halted", 1, int'(halted[1]), 0);
    chk("g_async_stall", 1, int'(stall_pc[1]), 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;

    // Randomised traffic on all three instances.
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) do_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        id_valid[i]     = ($urandom_range(0, 9) < 8);
        id_rs1[i]       = 5'($urandom_range(0, 3));
        id_rs2[i]       = 5'($urandom_range(0, 3));
        id_use_rs1[i]   = ($urandom_range(0, 3) != 0);
        id_use_rs2[i]   = ($urandom_range(0, 1) != 0);
        id_rd[i]        = 5'($urandom_range(0, 3));
        id_reg_write[i] = ($urandom_range(0, 9) < 7);
        id_mem_read[i]  = id_reg_write[i] && ($urandom_range(0, 9) < 4);
        id_halt[i]      = ($urandom_range(0, 149) == 0);
        ex_redirect[i]  = ($urandom_range(0, 9) == 0);
      end
    end

    @(negedge clk);
    for (int i = 0; i < 3; i++) idle(i);
    @(negedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Centralised pipeline control for the next-generation RISC-V core. It tracks in-flight destination registers from EX through WB, and from them decides load-use stalls, per-operand forwarding selects and control-hazard flushes. It also drains the pipeline on a halt instruction. Unlike the fixed five-stage hazard/forwarding pair, the memory stage count is parametrised. The datapath consumes its stall, flush, bubble and select outputs directly.

## Interface
- RF_ADDRESS, 5: register-address width.
- MEM_STAGES, 1: number of memory pipeline stages (1..3). Load data becomes forwardable only in WB.
- SEL_W, $clog2(MEM_STAGES+2): forward-select width (derived; not overridden).
- clk  in  1  clock.
- reset  in  1  reset; asynchronous and active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  RF_ADDRESS  ID source registers.
- id_use_rs1, id_use_rs2  in  1  the source is actually read.
- id_rd  in  RF_ADDRESS  ID destination.
- id_reg_write, id_mem_read, id_halt  in  1  ID decode flags (id_halt: opcode 7'b1111111).
- ex_redirect  in  1  taken branch or jump resolved in EX.
- stall_pc, stall_ifid  out  1  hold PC and the IF/ID register.
- flush_ifid  out  1  clear IF/ID.
- bubble_idex  out  1  load a NOP into ID/EX.
- fwd_a_sel, fwd_b_sel  out  SEL_W  EX operand source.
- halted  out  1  pipeline drained after halt.
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration).

## Operation
- Stage records {valid, rd, reg_write, mem_read} exist for EX, MEM1..MEM_STAGES and WB. ex_rs1/ex_rs2/ex_use are kept alongside EX.
- Each clock, records shift one stage toward WB.
- EX loads the ID fields when ID advances. EX loads invalid when bubble_idex is asserted.
- Producer match: record valid && reg_write && rd != 0 && rd == source && use bit set.
- Load-use stall: ID matches a load in EX..MEM_{MEM_STAGES-1}, at distance 1..MEM_STAGES ahead of ID. When stalled:
  - stall_pc=1, stall_ifid=1, bubble_idex=1.
- Forward select for each EX operand: 0 = register file; k = MEMk ALU result (1..MEM_STAGES); MEM_STAGES+1 = WB data.
  - The youngest matching record wins (smallest k).
  - A load in MEMk never drives a select; this cannot occur after a correct stall.
- ex_redirect: flush_ifid=1 and bubble_idex=1. It overrides the stall, so stall_pc=0 in that cycle.
- Halt FSM with states RUN, DRAIN and HALTED:
  - RUN→DRAIN: id_valid && id_halt && !ex_redirect && no stall.
  - In DRAIN: stall_pc=1, stall_ifid=1, bubble_idex=1, and a drain counter loads MEM_STAGES+2.
  - DRAIN→HALTED: when the counter reaches 0.
  - HALTED is sticky until reset; halted=1 only in HALTED.
  - ex_redirect during DRAIN is ignored, because older instructions cannot redirect.

## Timing
- Stall, flush, bubble and select outputs are combinational from the registered records plus the current ID inputs: zero-cycle decision.
- Records, FSM and counters update on the rising edge of clk.
- Reset (asynchronous, any cycle, including mid-DRAIN): all records invalid, FSM=RUN, drain counter=0, halted=0, counters=0.
  - With id_valid=0 and ex_redirect=0, every output is 0 immediately.
- Load-use penalty: exactly one bubble per cycle that a load sits in EX..MEM_{MEM_STAGES-1}.
  - For MEM_STAGES=1 this is one cycle.
  - For MEM_STAGES=3 it is up to three cycles.
- Halt latency: halted rises MEM_STAGES+3 cycles after the halt is accepted in ID.
- Simultaneous events:
  - Redirect beats stall and beats halt entry; a halt in ID at the same time is wrong-path and is flushed.
  - Stall beats halt entry; halt is re-evaluated once the stall clears.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments every cycle load-use stall is active.
  - flush_cnt increments every cycle ex_redirect flushes.
  - Both wrap modulo 2^32 and clear on reset.
- HAZARD_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Package pipe_ctrl_pkg holds:
  - stage_rec_t struct.
  - halt_state_e enum (RUN, DRAIN, HALTED).
  - FWD_RF=0 constant.
- One sub-module, fwd_select: priority match of one source register against the record array, producing SEL_W. It is instantiated twice, for A and B.

## Test plan
- MEM_STAGES=1: `lw x5` followed by `add x6,x5,x1` → one cycle of stall_pc/bubble_idex=1, then fwd_a_sel=2 (WB).
- MEM_STAGES=1: `add x5` then `sub x7,x5,x5` → no stall, fwd_a_sel=fwd_b_sel=1.
- MEM_STAGES=3: `lw x9` followed by a user of x9 → three stall cycles, then fwd select=4.
- Writes to x0 followed by reads of x0 → never stall, select stays 0.
- ex_redirect asserted in the same cycle as a load-use stall and id_halt → flush_ifid=1, stall_pc=0, FSM stays RUN.
- Halt accepted with MEM_STAGES=2 → halted=1 after exactly 5 cycles. Reset asserted mid-DRAIN → halted=0 and FSM=RUN asynchronously.
  - With HAZARD_PERF_EN, stall_cnt equals the number of stall cycles.
